// File: rtl/vga_pkg.sv
// Shared types and default frame geometry for the VGA fetch path.
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        REQ   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam int DEF_WORDS_PER_LINE  = 640;
    localparam int DEF_LINES_PER_FRAME = 480;
    localparam int DEF_LINE_STRIDE     = 2560;
    localparam int DEF_BYTES_PER_WORD  = 4;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Line/frame address generator: tracks line_addr, word_cnt and line_cnt and
// derives the next burst address and length (bursts never cross a line end).
module vga_fetch_addr_gen import vga_pkg::*; #(
    parameter int ADDR_W          = 32,
    parameter int BURST_LEN       = 16,
    parameter int BURST_W         = 5,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int LINE_STRIDE     = DEF_LINE_STRIDE,
    parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               advance_i,
    input  logic [ADDR_W-1:0]  base_addr_i,
    output logic [ADDR_W-1:0]  burst_addr_o,
    output logic [BURST_W-1:0] len_o,
    output logic               line_end_o,
    output logic               frame_end_o
);
    localparam int WCW = $clog2(WORDS_PER_LINE + 1);
    localparam int LCW = $clog2(LINES_PER_FRAME + 1);

    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [WCW-1:0]    word_cnt_q, word_cnt_d, remain;
    logic [LCW-1:0]    line_cnt_q, line_cnt_d;

    assign remain       = WCW'(WORDS_PER_LINE) - word_cnt_q;
    assign len_o        = (remain < WCW'(BURST_LEN)) ? BURST_W'(remain) : BURST_W'(BURST_LEN);
    assign burst_addr_o = line_addr_q + ADDR_W'(word_cnt_q) * ADDR_W'(BYTES_PER_WORD);
    // The pending burst finishes the line exactly when it covers every remaining word.
    assign line_end_o   = (remain == WCW'(len_o));
    assign frame_end_o  = line_end_o && (line_cnt_q == LCW'(LINES_PER_FRAME - 1));

    always_comb begin
        line_addr_d = line_addr_q;
        word_cnt_d  = word_cnt_q;
        line_cnt_d  = line_cnt_q;
        if (load_i) begin
            line_addr_d = base_addr_i;
            word_cnt_d  = '0;
            line_cnt_d  = '0;
        end else if (advance_i) begin
            if (line_end_o) begin
                word_cnt_d  = '0;
                line_cnt_d  = line_cnt_q + LCW'(1);
                line_addr_d = line_addr_q + ADDR_W'(LINE_STRIDE);
            end else begin
                word_cnt_d = word_cnt_q + WCW'(len_o);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            line_addr_q <= '0;
            word_cnt_q  <= '0;
            line_cnt_q  <= '0;
        end else begin
            line_addr_q <= line_addr_d;
            word_cnt_q  <= word_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

endmodule

// File: rtl/vga_fetch_sched.sv
// Write-side fetch scheduler: Avalon-MM burst reads of one frame into the pixel FIFO.
// Optional FETCH_DROP_CNT_EN adds drop_cnt/drop_err for words written while the FIFO is full.
module vga_fetch_sched import vga_pkg::*; #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int BURST_LEN       = 16,
    parameter int BURST_W         = 5,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int LINE_STRIDE     = DEF_LINE_STRIDE,
    parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic               fifo_almost_full,
    input  logic               fifo_full,
    output logic               fifo_wr_valid,
    output logic [DATA_W-1:0]  fifo_wr_data,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_read,
    output logic [BURST_W-1:0] avm_burstcount,
    input  logic               avm_waitrequest,
    input  logic [DATA_W-1:0]  avm_readdata,
    input  logic               avm_readdatavalid,
    output logic               busy,
    output state_t             state_dbg,
    output logic               frame_done
`ifdef FETCH_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt,
    output logic               drop_err
`endif
);
    // Avalon read: a request is accepted on a cycle with avm_read=1 and
    // avm_waitrequest=0; address/burstcount stay frozen until then.
    state_t             state_q;
    logic               restart_q;
    logic [BURST_W-1:0] rcv_cnt_q;
    logic [ADDR_W-1:0]  ag_addr;
    logic [BURST_W-1:0] ag_len;
    logic               ag_line_end, ag_frame_end;
    logic               restart_pend, start_req, last_word, burst_done;

    assign restart_pend  = restart_q | frame_start;
    assign start_req     = (state_q == IDLE) && restart_pend && enable;
    assign fifo_wr_valid = (state_q == WAIT) && avm_readdatavalid;
    assign fifo_wr_data  = fifo_wr_valid ? avm_readdata : '0;
    assign last_word     = (rcv_cnt_q + BURST_W'(1)) == avm_burstcount;
    assign burst_done    = fifo_wr_valid && last_word;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;

    vga_fetch_addr_gen #(
        .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .BURST_W(BURST_W),
        .WORDS_PER_LINE(WORDS_PER_LINE), .LINES_PER_FRAME(LINES_PER_FRAME),
        .LINE_STRIDE(LINE_STRIDE), .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_addr_gen (
        .clk_i(clk), .reset_i(reset), .load_i(start_req), .advance_i(burst_done),
        .base_addr_i(base_addr), .burst_addr_o(ag_addr), .len_o(ag_len),
        .line_end_o(ag_line_end), .frame_end_o(ag_frame_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            restart_q      <= 1'b0;
            rcv_cnt_q      <= '0;
            avm_read       <= 1'b0;
            avm_address    <= '0;
            avm_burstcount <= '0;
            frame_done     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frame_start && state_q != IDLE) restart_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    restart_q <= 1'b0;
                    if (start_req) state_q <= CHECK;
                end
                CHECK: if (!fifo_almost_full) begin
                    state_q        <= REQ;
                    avm_read       <= 1'b1;
                    avm_address    <= ag_addr;
                    avm_burstcount <= ag_len;
                    rcv_cnt_q      <= '0;
                end
                REQ: if (!avm_waitrequest) begin
                    avm_read <= 1'b0;
                    state_q  <= WAIT;
                end
                WAIT: if (avm_readdatavalid) begin
                    rcv_cnt_q <= rcv_cnt_q + BURST_W'(1);
                    if (last_word) begin
                        // A pending restart wins over frame completion: no frame_done.
                        if (restart_pend) begin
                            state_q   <= IDLE;
                            restart_q <= 1'b1;
                        end else if (ag_line_end && ag_frame_end) begin
                            state_q    <= IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            state_q <= CHECK;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            drop_err <= 1'b0;
        end else if (fifo_wr_valid && fifo_full) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            drop_err <= 1'b1;
        end
    end
`else
    logic fifo_full_unused;
    assign fifo_full_unused = fifo_full;
`endif

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Self-checking bench for vga_fetch_sched: directed frame table, protocol corner
// cases and randomized frames against a burst/data reference model.
module tb_vga_fetch_sched;
  import vga_pkg::*;

  localparam int WPL = 40;
  localparam int LPF = 2;
  localparam int BL = 16;
  localparam int STRIDE = 2560;
  localparam int BPW = 4;
  localparam logic [31:0] TAG = 32'h5A5A_0000;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b1, frame_start = 1'b0;
  logic [31:0] base_addr = '0;
  logic fifo_almost_full = 1'b0, fifo_full = 1'b0;
  logic fifo_wr_valid, avm_read, busy, frame_done;
  logic [31:0] fifo_wr_data, avm_address;
  logic [4:0] avm_burstcount;
  logic avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  state_t state_dbg;
`ifdef FETCH_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic drop_err;
`endif

  vga_fetch_sched #(
    .DATA_W(32), .ADDR_W(32), .BURST_LEN(BL), .BURST_W(5), .WORDS_PER_LINE(WPL),
    .LINES_PER_FRAME(LPF), .LINE_STRIDE(STRIDE), .BYTES_PER_WORD(BPW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .base_addr(base_addr), .fifo_almost_full(fifo_almost_full), .fifo_full(fifo_full),
    .fifo_wr_valid(fifo_wr_valid), .fifo_wr_data(fifo_wr_data),
    .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .busy(busy), .state_dbg(state_dbg),
    .frame_done(frame_done)
`ifdef FETCH_DROP_CNT_EN
    , .drop_cnt(drop_cnt), .drop_err(drop_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] off; int len; } vec_t;
  vec_t tbl[6];

  int checks = 0, failures = 0;
  int cyc = 0, n_wr = 0, n_fd = 0, n_grant = 0, n_read_cyc = 0;
  logic [31:0] exp_q[$];
  logic [63:0] exp_b_q[$];
  logic [63:0] grant_log[$];
  logic [31:0] sl_q[$];
  int sl_ready = 0;
  bit rand_wait = 0, rand_gap = 0, rand_af = 0;
  int wait_budget = 0, ff_words = 0;
  logic prev_read = 0, prev_wait = 0;
  logic [31:0] prev_addr = '0;
  logic [4:0] prev_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: every burst of a frame and the word each FIFO write must carry.
  task automatic model_frame(input logic [31:0] base);
    for (int ln = 0; ln < LPF; ln++) begin
      int w = 0;
      while (w < WPL) begin
        int len = (WPL - w < BL) ? (WPL - w) : BL;
        logic [31:0] a = base + 32'(ln * STRIDE) + 32'(w * BPW);
        exp_b_q.push_back({a, 32'(len)});
        for (int k = 0; k < len; k++) exp_q.push_back((a + 32'(k * BPW)) ^ TAG);
        w += len;
      end
    end
  endtask

  task automatic sample();
    if (fifo_wr_valid) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected actual=0x%0h expected=none", fifo_wr_data);
      end else check("wr_data", fifo_wr_data, exp_q.pop_front());
    end
    if (frame_done) n_fd++;
    if (avm_read) n_read_cyc++;
    if (!reset && prev_read && prev_wait) begin
      check("req_hold_read", avm_read, 1'b1);
      check("req_hold_addr", avm_address, prev_addr);
      check("req_hold_cnt", avm_burstcount, prev_cnt);
    end
    if (avm_read && !avm_waitrequest) begin
      n_grant++;
      grant_log.push_back({avm_address, 27'd0, avm_burstcount});
      if (exp_b_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL grant_unexpected actual=0x%0h expected=none", avm_address);
      end else begin
        logic [63:0] b = exp_b_q.pop_front();
        check("grant_addr", avm_address, b[63:32]);
        check("grant_len", avm_burstcount, b[31:0]);
      end
      for (int k = 0; k < int'(avm_burstcount); k++)
        sl_q.push_back((avm_address + 32'(k * BPW)) ^ TAG);
      sl_ready = cyc + 4;
    end
    prev_read = avm_read; prev_wait = avm_waitrequest;
    prev_addr = avm_address; prev_cnt = avm_burstcount;
  endtask

  task automatic step();
    @(posedge clk); cyc++;
    #1;
    if (sl_q.size() > 0 && cyc >= sl_ready && !(rand_gap && $urandom_range(0, 3) == 0)) begin
      avm_readdatavalid = 1'b1; avm_readdata = sl_q.pop_front();
      if (ff_words > 0) begin fifo_full = 1'b1; ff_words--; end else fifo_full = 1'b0;
    end else begin
      avm_readdatavalid = 1'b0; avm_readdata = $urandom; fifo_full = 1'b0;
    end
    if (avm_read && wait_budget > 0) begin avm_waitrequest = 1'b1; wait_budget--; end
    else avm_waitrequest = rand_wait ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (rand_af) fifo_almost_full = ($urandom_range(0, 3) == 0);
    #1;
    sample();
  endtask

  task automatic start_frame(input logic [31:0] base);
    base_addr = base; frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_until_done(input string name);
    int fd0 = n_fd;
    int i = 0;
    while (n_fd == fd0 && i < 3000) begin step(); i++; end
    check(name, n_fd - fd0, 1);
    check({name, "_data_left"}, exp_q.size(), 0);
    check({name, "_burst_left"}, exp_b_q.size(), 0);
  endtask

  initial begin
    int wr0, fd0, g0, rc0, bad, i;
    tbl[0] = '{32'd0, 16};    tbl[1] = '{32'd64, 16};   tbl[2] = '{32'd128, 8};
    tbl[3] = '{32'd2560, 16}; tbl[4] = '{32'd2624, 16}; tbl[5] = '{32'd2688, 8};

    repeat (3) step();
    check("rst_read", avm_read, 0);
    check("rst_addr", avm_address, 0);
    check("rst_cnt", avm_burstcount, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", fifo_wr_valid, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", state_dbg, IDLE);
`ifdef FETCH_DROP_CNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_drop_err", drop_err, 0);
`endif
    reset = 1'b0;
    step();

    // Directed frame compared against the fixed burst table.
    grant_log.delete(); wr0 = n_wr; fd0 = n_fd;
    model_frame(32'h0010_0000);
    start_frame(32'h0010_0000);
    run_until_done("t1_done");
    check("t1_writes", n_wr - wr0, 80);
    check("t1_grants", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      check("t1_tbl_addr", grant_log[k][63:32], 32'h0010_0000 + tbl[k].off);
      check("t1_tbl_len", grant_log[k][31:0], 32'(tbl[k].len));
    end
    repeat (3) step();
    check("t1_single_pulse", n_fd - fd0, 1);
    check("t1_idle_busy", busy, 0);

    // enable low: frame_start ignored.
    enable = 1'b0;
    start_frame(32'h0000_4000);
    repeat (3) step();
    check("en_low_busy", busy, 0);
    check("en_low_read", avm_read, 0);
    enable = 1'b1;

    // waitrequest held for 5 cycles on the first request.
    wait_budget = 5; rc0 = n_read_cyc; g0 = n_grant;
    model_frame(32'h0020_0000);
    start_frame(32'h0020_0000);
    i = 0;
    while (n_grant == g0 && i < 100) begin step(); i++; end
    check("wr_req_cycles", n_read_cyc - rc0, 6);
    check("wr_one_accept", n_grant - g0, 1);
    run_until_done("t2_done");
    check("t2_grants", n_grant - g0, 6);

    // almost_full held while in CHECK.
    model_frame(32'h0030_0000);
    start_frame(32'h0030_0000);
    check("af_state_check", state_dbg, CHECK);
    fifo_almost_full = 1'b1; bad = 0;
    repeat (20) begin step(); if (avm_read) bad++; end
    check("af_no_read", bad, 0);
    fifo_almost_full = 1'b0;
    step();
    check("af_read_after", avm_read, 1);
    run_until_done("t3_done");

    // frame_start in the middle of the second burst.
    rand_gap = 1; wr0 = n_wr; fd0 = n_fd; g0 = n_grant;
    model_frame(32'h0040_0000);
    start_frame(32'h0040_0000);
    i = 0;
    while (n_wr - wr0 < 21 && i < 500) begin step(); i++; end
    check("rs_progress", n_wr - wr0, 21);
    while (exp_q.size() > 32 - (n_wr - wr0)) void'(exp_q.pop_back());
    exp_b_q.delete();
    model_frame(32'h0000_1000);
    start_frame(32'h0000_1000);
    run_until_done("rs_done");
    check("rs_no_early_done", n_fd - fd0, 1);
    check("rs_writes", n_wr - wr0, 32 + 80);
    check("rs_grants", n_grant - g0, 2 + 6);
    rand_gap = 0;

    // Stray readdatavalid while idle.
    repeat (2) step();
    avm_readdatavalid = 1'b1; avm_readdata = 32'hDEAD_BEEF;
    #1;
    check("stray_wr_valid", fifo_wr_valid, 0);
    check("stray_wr_data", fifo_wr_data, 0);
    wr0 = n_wr;
    step();
    check("stray_no_write", n_wr - wr0, 0);

    // Randomized frames against the reference model.
    rand_wait = 1; rand_gap = 1; rand_af = 1;
    for (int f = 0; f < 4; f++) begin
      logic [31:0] b = $urandom & 32'hFFFF_FFFC;
      wr0 = n_wr;
      enable = 1'b1;
      model_frame(b);
      start_frame(b);
      if (f == 1) enable = 1'b0;
      run_until_done("rnd_done");
      check("rnd_writes", n_wr - wr0, 80);
    end
    rand_wait = 0; rand_gap = 0; rand_af = 0; fifo_almost_full = 1'b0; enable = 1'b1;

`ifdef FETCH_DROP_CNT_EN
    ff_words = 3;
    model_frame(32'h0050_0000);
    start_frame(32'h0050_0000);
    run_until_done("drop_done");
    check("drop_cnt", drop_cnt, 3);
    check("drop_err", drop_err, 1);
`endif

    // Reset while waiting for burst data.
    model_frame(32'h0060_0000);
    start_frame(32'h0060_0000);
    i = 0;
    while (state_dbg != WAIT && i < 100) begin step(); i++; end
    check("rw_in_wait", state_dbg, WAIT);
    reset = 1'b1;
    step();
    check("rw_state", state_dbg, IDLE);
    check("rw_read", avm_read, 0);
    check("rw_addr", avm_address, 0);
    check("rw_cnt", avm_burstcount, 0);
    check("rw_busy", busy, 0);
    check("rw_wr_valid", fifo_wr_valid, 0);
    check("rw_frame_done", frame_done, 0);
`ifdef FETCH_DROP_CNT_EN
    check("rw_drop_cnt", drop_cnt, 0);
    check("rw_drop_err", drop_err, 0);
`endif
    sl_q.delete(); exp_q.delete(); exp_b_q.delete();
    reset = 1'b0;
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
